// File: rtl/mb_rtu_frame_rx_pkg.sv
// Shared Modbus RTU definitions: receiver states, CRC16 constants, error-bit layout.
// Intended to be reused by the future frame transmitter.
package mb_rtu_frame_rx_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_RECV  = 2'd2,
        ST_HOLD  = 2'd3
    } rx_state_e;

    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // frame_err = {ovf, gap, short, crc}
    localparam int unsigned ERR_CRC   = 0;
    localparam int unsigned ERR_SHORT = 1;
    localparam int unsigned ERR_GAP   = 2;
    localparam int unsigned ERR_OVF   = 3;

    localparam logic [7:0]  MB_BCAST_ADDR = 8'h00;
    localparam int unsigned MIN_FRAME_LEN = 4;

endpackage

// File: rtl/mb_crc16_byte.sv
// One-byte step of the Modbus CRC16 (reflected, poly 0xA001), purely combinational.
module mb_crc16_byte
    import mb_rtu_frame_rx_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_c_o
);

    logic [15:0] crc_w;

    always_comb begin
        crc_w = crc_i ^ {8'h00, data_i};
        for (int i = 0; i < 8; i++) begin
            crc_w = crc_w[0] ? ((crc_w >> 1) ^ CRC_POLY) : (crc_w >> 1);
        end
        crc_c_o = crc_w;
    end

endmodule

// File: rtl/mb_rtu_frame_rx.sv
// Modbus RTU frame receiver: silence-delimited framing, on-the-fly CRC16 check,
// address filtering and a held frame buffer read by the command decoder.
module mb_rtu_frame_rx
    import mb_rtu_frame_rx_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR = 8'h01,
    parameter int unsigned MAX_LEN    = 256,
    parameter int unsigned T15_CYCLES = 85938,
    parameter int unsigned T35_CYCLES = 200521,
    localparam int unsigned AW        = $clog2(MAX_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          frame_rdy,
    output logic          frame_done,
    output logic [AW:0]   frame_len,
    output logic [3:0]    frame_err,
    output logic          frame_bcast,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          rx_drop
);

    localparam int unsigned TW = $clog2(T35_CYCLES + 1);
    localparam int unsigned LW = AW + 1;
    localparam logic [TW-1:0] T15     = TW'(T15_CYCLES);
    localparam logic [TW-1:0] T35     = TW'(T35_CYCLES);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [LW-1:0] LEN_MIN = LW'(MIN_FRAME_LEN);

    rx_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   crc_q;
    logic [LW-1:0] len_q;
    logic [7:0]    addr_q;
    logic          ovf_q;
    logic          gap_q;

    logic          frame_rdy_q;
    logic          frame_done_q;
    logic [LW-1:0] frame_len_q;
    logic [3:0]    frame_err_q;
    logic          frame_bcast_q;
    logic [7:0]    rd_data_q;
    logic          rx_drop_q;

    logic [7:0]    mem_q [MAX_LEN];

    logic          timer_end_c;
    logic [15:0]   crc_in_c;
    logic [15:0]   crc_upd_c;
    logic          wr_en_c;
    logic [AW-1:0] wr_addr_c;

    // Bus idle timer: counts silent cycles since the last byte, saturating at 3.5 chars
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (rx_valid) begin
            timer_q <= '0;
        end else if (timer_q != T35) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    assign timer_end_c = (timer_q == T35);
    assign crc_in_c    = (state_q == ST_READY) ? CRC_INIT : crc_q;
    assign wr_addr_c   = (state_q == ST_READY) ? '0 : len_q[AW-1:0];
    assign wr_en_c     = rx_valid &&
                         ((state_q == ST_READY) ||
                          ((state_q == ST_RECV) && !timer_end_c && (len_q != LEN_MAX)));

    mb_crc16_byte u_crc (
        .crc_i   (crc_in_c),
        .data_i  (rx_data),
        .crc_c_o (crc_upd_c)
    );

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_addr_c] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            crc_q         <= CRC_INIT;
            len_q         <= '0;
            addr_q        <= '0;
            ovf_q         <= 1'b0;
            gap_q         <= 1'b0;
            frame_rdy_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_len_q   <= '0;
            frame_err_q   <= '0;
            frame_bcast_q <= 1'b0;
            rd_data_q     <= '0;
            rx_drop_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            rx_drop_q    <= 1'b0;
            rd_data_q    <= mem_q[rd_addr];
            unique case (state_q)
                ST_INIT: begin
                    if (timer_end_c) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (rx_valid) begin
                        crc_q   <= crc_upd_c;
                        len_q   <= LW'(1);
                        addr_q  <= rx_data;
                        ovf_q   <= 1'b0;
                        gap_q   <= 1'b0;
                        state_q <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (timer_end_c) begin
                        // Foreign addresses are dropped without any indication
                        if ((addr_q != SLAVE_ADDR) && (addr_q != MB_BCAST_ADDR)) begin
                            state_q <= ST_READY;
                        end else begin
                            state_q                <= ST_HOLD;
                            frame_done_q           <= 1'b1;
                            frame_rdy_q            <= 1'b1;
                            frame_len_q            <= len_q;
                            frame_err_q[ERR_OVF]   <= ovf_q;
                            frame_err_q[ERR_GAP]   <= gap_q;
                            frame_err_q[ERR_SHORT] <= (len_q < LEN_MIN);
                            frame_err_q[ERR_CRC]   <= (crc_q != 16'h0000);
                            frame_bcast_q          <= (addr_q == MB_BCAST_ADDR);
                        end
                    end else if (rx_valid) begin
                        if (timer_q >= T15) begin
                            gap_q <= 1'b1;
                        end
                        if (len_q == LEN_MAX) begin
                            ovf_q <= 1'b1;
                        end else begin
                            crc_q <= crc_upd_c;
                            len_q <= len_q + LW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (rx_valid) begin
                        rx_drop_q <= 1'b1;
                    end
                    // Release straight to READY only if the bus is already known silent
                    if (frame_ack) begin
                        frame_rdy_q <= 1'b0;
                        state_q     <= (timer_end_c && !rx_valid) ? ST_READY : ST_INIT;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign frame_rdy   = frame_rdy_q;
    assign frame_done  = frame_done_q;
    assign frame_len   = frame_len_q;
    assign frame_err   = frame_err_q;
    assign frame_bcast = frame_bcast_q;
    assign rd_data     = rd_data_q;
    assign rx_drop     = rx_drop_q;

endmodule

// File: tb/tb_mb_rtu_frame_rx.sv
// Randomised self-checking bench for mb_rtu_frame_rx with a frame-level reference model.
module tb_mb_rtu_frame_rx;

    localparam logic [7:0]  SLAVE = 8'h01;
    localparam int unsigned MAXL  = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned T15   = 60;
    localparam int unsigned T35   = 150;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          frame_rdy;
    logic          frame_done;
    logic [AW:0]   frame_len;
    logic [3:0]    frame_err;
    logic          frame_bcast;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_ack;
    logic          rx_drop;

    mb_rtu_frame_rx #(
        .SLAVE_ADDR (SLAVE),
        .MAX_LEN    (MAXL),
        .T15_CYCLES (T15),
        .T35_CYCLES (T35)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_rdy   (frame_rdy),
        .frame_done  (frame_done),
        .frame_len   (frame_len),
        .frame_err   (frame_err),
        .frame_bcast (frame_bcast),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ack   (frame_ack),
        .rx_drop     (rx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [3:0] err;
        logic       bcast;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         checks;
    int         errors;
    int         done_cnt;
    int         drop_cnt;
    bit         model_hold;
    logic [7:0] fb [16];
    int         fg [16];
    int         fn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial Modbus CRC16 over fb[0..n-1]
    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ((c[0] ^ fb[i][b]) == 1'b1) c = (c >> 1) ^ 16'hA001;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic bit accepted();
        return (fb[0] == SLAVE) || (fb[0] == 8'h00);
    endfunction

    function automatic exp_t model();
        exp_t e;
        int   stored;
        bit   gap;
        stored = (fn > int'(MAXL)) ? int'(MAXL) : fn;
        gap = 1'b0;
        for (int i = 1; i < fn; i++) if (fg[i] - 1 >= int'(T15)) gap = 1'b1;
        e.len   = stored;
        e.err   = {fn > int'(MAXL), gap, stored < 4, ref_crc(stored) != 16'h0000};
        e.bcast = (fb[0] == 8'h00);
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < fn; i++) begin
            if (i > 0) idle(fg[i] - 1);
            send_byte(fb[i]);
        end
    endtask

    task automatic load_t1();
        logic [7:0] t1 [8];
        t1 = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h95, 8'hCB};
        fn = 8;
        for (int i = 0; i < 8; i++) begin
            fb[i] = t1[i];
            fg[i] = int'($urandom_range(1, 40));
        end
    endtask

    task automatic wait_done(input string name, input int prev);
        for (int k = 0; k < int'(T35) + 20 && done_cnt == prev; k++) @(negedge clk);
        check({name, " done"}, 32'(done_cnt - prev), 32'd1);
        if (done_cnt == prev) exp_q.delete();
    endtask

    task automatic read_back(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            @(negedge clk);
            check({name, " rd"}, 32'(rd_data), 32'(fb[i]));
        end
    endtask

    task automatic release_frame();
        frame_ack  = 1'b1;
        model_hold = 1'b0;
        @(negedge clk);
        frame_ack  = 1'b0;
    endtask

    // ignore=1: the receiver is expected to be deaf (INIT), so nothing may come out
    task automatic run_frame(input string name, input bit ignore, input bit use_lit,
                             input int lit_len, input logic [3:0] lit_err, input logic lit_bcast);
        exp_t e;
        int   prev;
        bit   acc;
        e    = model();
        acc  = accepted() && !ignore;
        prev = done_cnt;
        if (acc) exp_q.push_back(e);
        send_frame();
        if (acc) begin
            wait_done(name, prev);
            if (done_cnt != prev) begin
                if (use_lit) begin
                    check({name, " len"}, 32'(frame_len), 32'(lit_len));
                    check({name, " err"}, 32'(frame_err), 32'(lit_err));
                    check({name, " bcast"}, 32'(frame_bcast), 32'(lit_bcast));
                end
                read_back(name, e.len);
                release_frame();
            end
        end else begin
            idle(int'(T35) + 20);
            check({name, " nodone"}, 32'(done_cnt - prev), 32'd0);
        end
    endtask

    // Every-cycle comparison of the held-frame outputs against the model
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            if (frame_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected frame_done: got 1 expected 0");
                end else begin
                    cur        = exp_q.pop_front();
                    model_hold = 1'b1;
                    done_cnt++;
                end
            end
            if (rx_drop) drop_cnt++;
            check("frame_rdy", 32'(frame_rdy), 32'(model_hold));
            if (model_hold) begin
                check("held len", 32'(frame_len), 32'(cur.len));
                check("held err", 32'(frame_err), 32'(cur.err));
                check("held bcast", 32'(frame_bcast), 32'(cur.bcast));
            end
        end
    end

    initial begin
        int         prev;
        logic [15:0] c;
        int         k;
        checks = 0; errors = 0; done_cnt = 0; drop_cnt = 0; model_hold = 1'b0;
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0; rd_addr = '0; frame_ack = 1'b0;
        idle(3);
        check("rst frame_rdy", 32'(frame_rdy), 32'd0);
        check("rst frame_done", 32'(frame_done), 32'd0);
        check("rst frame_len", 32'(frame_len), 32'd0);
        check("rst frame_err", 32'(frame_err), 32'd0);
        check("rst frame_bcast", 32'(frame_bcast), 32'd0);
        check("rst rd_data", 32'(rd_data), 32'd0);
        check("rst rx_drop", 32'(rx_drop), 32'd0);
        rst = 1'b0;
        idle(int'(T35) + 10);

        load_t1();
        check("model crc pin", 32'(ref_crc(6)), 32'h0000CB95);
        run_frame("t1 good", 1'b0, 1'b1, 8, 4'b0000, 1'b0);

        load_t1(); fb[7] = 8'hCC;
        run_frame("t2 badcrc", 1'b0, 1'b1, 8, 4'b0001, 1'b0);
        load_t1(); fn = 2;
        run_frame("t2 short", 1'b0, 1'b1, 2, 4'b0011, 1'b0);

        load_t1(); fb[0] = 8'h02;
        run_frame("t3 foreign", 1'b0, 1'b0, 0, 4'b0000, 1'b0);
        load_t1();
        run_frame("t3 after foreign", 1'b0, 1'b1, 8, 4'b0000, 1'b0);
        load_t1(); fb[0] = 8'h00; fb[1] = 8'h06; fb[5] = 8'h03;
        c = ref_crc(6); fb[6] = c[7:0]; fb[7] = c[15:8];
        run_frame("t3 bcast", 1'b0, 1'b1, 8, 4'b0000, 1'b1);

        load_t1(); fg[3] = 100;
        run_frame("t4 gap", 1'b0, 1'b1, 8, 4'b0100, 1'b0);

        load_t1(); fn = 10; fb[8] = 8'h5A; fb[9] = 8'hA5; fg[8] = 7; fg[9] = 9;
        run_frame("t5 ovf", 1'b0, 1'b1, 8, 4'b1000, 1'b0);

        // Byte in HOLD is dropped; ack with a coincident byte forces fresh silence
        load_t1();
        exp_q.push_back(model());
        prev = done_cnt;
        send_frame();
        wait_done("t6 hold", prev);
        prev = drop_cnt;
        send_byte(8'hAA);
        idle(1);
        check("t6 drop", 32'(drop_cnt - prev), 32'd1);
        read_back("t6 unchanged", 8);
        rx_data = 8'h55; rx_valid = 1'b1; frame_ack = 1'b1; model_hold = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0; frame_ack = 1'b0;
        idle(1);
        check("t6 ack drop", 32'(drop_cnt - prev), 32'd2);
        idle(5);
        load_t1();
        run_frame("t6 init deaf", 1'b1, 1'b0, 0, 4'b0000, 1'b0);
        load_t1();
        run_frame("t6 after init", 1'b0, 1'b1, 8, 4'b0000, 1'b0);

        // Reset mid-frame
        load_t1(); fn = 3;
        send_frame();
        rst = 1'b1; idle(2); rst = 1'b0;
        load_t1();
        run_frame("t6 post-rst deaf", 1'b1, 1'b0, 0, 4'b0000, 1'b0);
        load_t1();
        run_frame("t6 post-rst ok", 1'b0, 1'b1, 8, 4'b0000, 1'b0);

        for (int r = 0; r < 14; r++) begin
            case ($urandom_range(0, 3))
                0: fb[0] = 8'h01;
                1: fb[0] = 8'h00;
                2: fb[0] = 8'h02;
                default: fb[0] = 8'($urandom);
            endcase
            k = int'($urandom_range(0, 6));
            for (int i = 1; i <= k; i++) fb[i] = 8'($urandom);
            fn = k + 1;
            if ($urandom_range(0, 3) != 0) begin
                c = ref_crc(fn); fb[fn] = c[7:0]; fb[fn + 1] = c[15:8]; fn = fn + 2;
            end
            for (int i = 0; i < fn; i++)
                fg[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(80, 130))
                                                    : int'($urandom_range(1, 40));
            run_frame("rand", 1'b0, 1'b0, 0, 4'b0000, 1'b0);
        end

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
